// File: rtl/ifetch_unit.sv
// Instruction fetch front end: keeps up to two fetches in flight, buffers returned
// words in a 2-entry FIFO and handles load bubbles and branch/jalr redirects.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        insn_valid,
  input  logic        stall,
  input  logic        pc_add_sel,
  input  logic        pc_next_sel,
  input  logic [31:0] imm_val,
  input  logic [31:0] jalr_target,
  output logic        delayed_load,
  output logic [4:0]  delayed_rd
);

  typedef enum logic {RUN, LOAD2} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] last_pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_cnt;
  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_insn [2];

  logic        redirect;
  logic [31:0] target;
  logic        accept;
  logic        rsp_drop;
  logic        rsp_take;
  logic        push;
  logic        pop;
  logic [1:0]  out_nxt;
  logic [1:0]  drop_nxt;
  logic [31:0] rsp_pc;

  function automatic logic [31:0] redirect_target(
    input logic        use_jalr,
    input logic [31:0] jalr_addr,
    input logic [31:0] base,
    input logic [31:0] offset
  );
    logic [31:0] t;
    t = use_jalr ? jalr_addr : base + offset;
    return {t[31:2], 2'b00};
  endfunction

  always_comb begin
    insn_valid     = (count != 2'd0) && (state == RUN);
    instruction    = insn_valid ? fifo_insn[rd_ptr] : NOP_INSN;
    pc             = insn_valid ? fifo_pc[rd_ptr] : last_pc;
    delayed_load   = (state == LOAD2);
    redirect       = insn_valid && !stall && (pc_add_sel || pc_next_sel);
    target         = redirect_target(pc_next_sel, jalr_target, pc, imm_val);
    imem_addr      = fetch_pc;
    imem_req_valid = rst && !redirect && (({1'b0, outstanding} + {1'b0, count}) < 3'd2);
    accept         = imem_req_valid && imem_req_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != 2'd0);
    rsp_take       = imem_rsp_valid && (drop_cnt == 2'd0);
    push           = rsp_take && !redirect;
    // A stalled load is consumed too; only a redirect leaves the head in place before the flush.
    pop            = insn_valid && !redirect;
    out_nxt        = outstanding + {1'b0, accept} - {1'b0, rsp_take};
    drop_nxt       = drop_cnt - {1'b0, rsp_drop};
    // Live requests are consecutive words ending just below fetch_pc, so the oldest one is recovered here.
    rsp_pc         = fetch_pc - {28'd0, outstanding, 2'b00};
  end

  // Control stage: fetch pointer, in-flight bookkeeping, FIFO occupancy and load FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      last_pc     <= 32'd0;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      delayed_rd  <= 5'd0;
    end else begin
      if (redirect) begin
        fetch_pc <= target;
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (insn_valid) begin
        last_pc <= fifo_pc[rd_ptr];
      end

      if (redirect) begin
        outstanding <= 2'd0;
        drop_cnt    <= drop_nxt + out_nxt;
        count       <= 2'd0;
        wr_ptr      <= 1'b0;
        rd_ptr      <= 1'b0;
      end else begin
        outstanding <= out_nxt;
        drop_cnt    <= drop_nxt;
        count       <= count + {1'b0, push} - {1'b0, pop};
        wr_ptr      <= wr_ptr ^ push;
        rd_ptr      <= rd_ptr ^ pop;
      end

      case (state)
        RUN: begin
          if (insn_valid && stall) begin
            state      <= LOAD2;
            delayed_rd <= instruction[11:7];
          end
        end
        LOAD2:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Data stage: FIFO storage, written only on push
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= rsp_pc;
      fifo_insn[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: randomized decode/memory behaviour against an
// architectural model of the expected instruction and fetch-address streams.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        insn_valid;
  logic        stall;
  logic        pc_add_sel;
  logic        pc_next_sel;
  logic [31:0] imm_val;
  logic [31:0] jalr_target;
  logic        delayed_load;
  logic [4:0]  delayed_rd;

  ifetch_unit #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instruction(instruction), .pc(pc), .insn_valid(insn_valid),
    .stall(stall), .pc_add_sel(pc_add_sel), .pc_next_sel(pc_next_sel),
    .imm_val(imm_val), .jalr_target(jalr_target),
    .delayed_load(delayed_load), .delayed_rd(delayed_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0, n_vec = 0, n_err = 0, n_cons = 0, lat = 1, last_due = 0;
  logic [31:0] exp_fetch = RESET_PC;
  bit          load_pend = 0, prev_hold = 0;
  logic [4:0]  exp_rd = 5'd0;
  logic [31:0] prev_addr = 32'd0;
  bit          d_load = 0, d_br = 0, d_jr = 0, d_wrap = 0, dir_done = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0F13;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard: everything is sampled on the falling edge
  always @(negedge clk) begin
    logic        cur_redir;
    logic [31:0] p, w, nx, tgt;
    pend_t       e;
    if (!rst) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_insn", instruction, NOP);
      chk("rst_pc", pc, 0);
      chk("rst_insn_valid", insn_valid, 0);
      chk("rst_dload", delayed_load, 0);
      chk("rst_drd", delayed_rd, 0);
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      exp_fetch = RESET_PC;
      load_pend = 0;
      prev_hold = 0;
      last_due  = 0;
    end else begin
      cur_redir = insn_valid && !load_pend && !stall && (pc_add_sel || pc_next_sel);
      if (prev_hold && !cur_redir) begin
        chk("req_held", imem_req_valid, 1);
        chk("addr_held", imem_addr, prev_addr);
      end
      prev_hold = imem_req_valid && !imem_req_ready;
      prev_addr = imem_addr;

      if (imem_req_valid && imem_req_ready) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        e.addr = imem_addr;
        e.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = e.due;
        pend_q.push_back(e);
      end

      if (load_pend) begin
        chk("load2_valid", insn_valid, 0);
        chk("load2_insn", instruction, NOP);
        chk("load2_dload", delayed_load, 1);
        chk("load2_rd", delayed_rd, exp_rd);
        load_pend = 0;
      end else if (insn_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_insn: got pc %h expected no instruction", pc);
        end else begin
          p = exp_q.pop_front();
          w = mem_word(p);
          chk("pc", pc, p);
          chk("instruction", instruction, w);
          chk("run_dload", delayed_load, 0);
          n_cons++;
          if (stall) begin
            load_pend = 1;
            exp_rd = w[11:7];
            nx = p + 32'd4;
            if (p == 32'h8) d_load = 1;
          end else if (pc_next_sel || pc_add_sel) begin
            tgt = pc_next_sel ? jalr_target : p + imm_val;
            tgt[1:0] = 2'b00;
            nx = tgt;
            exp_fetch = tgt;
            if (p == 32'h10 && pc_add_sel && !pc_next_sel) d_br = 1;
            if (p == 32'h14 && pc_next_sel) d_jr = 1;
            if (p == 32'h108 && pc_next_sel) d_wrap = 1;
          end else begin
            nx = p + 32'd4;
          end
          exp_q.push_back(nx);
        end
      end else begin
        chk("bubble_insn", instruction, NOP);
        chk("bubble_dload", delayed_load, 0);
      end
    end
  end

  // Driver: memory responder plus decode-side stimulus, applied just after the rising edge
  initial begin
    logic [31:0] front;
    pend_t       r;
    int          bp_left, sel;
    bp_left = 0;
    rst = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    stall = 1'b0; pc_add_sel = 1'b0; pc_next_sel = 1'b0; imm_val = 32'd0; jalr_target = 32'd0;
    for (int i = 0; i < 2200; i++) begin
      @(posedge clk);
      cyc++;
      #1;
      front = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
      rst = !(i < 3 || (i >= 1200 && i < 1203));
      stall = 1'b0; pc_add_sel = 1'b0; pc_next_sel = 1'b0;
      imm_val = 32'd0; jalr_target = 32'd0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
      if (!rst) begin
        pend_q.delete();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0000 | i;
        continue;
      end
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(r.addr);
      end
      if (!dir_done && d_wrap && front < 32'h100) begin
        dir_done = 1;
        bp_left  = 5;
      end
      if (!dir_done) begin
        lat   = 1;
        stall = (front == 32'h8) && !d_load;
        if (front == 32'h10 && !d_br) begin
          pc_add_sel = 1'b1; imm_val = 32'hFFFF_FFF0;
        end
        if (front == 32'h14 && !d_jr) begin
          pc_add_sel = 1'b1; pc_next_sel = 1'b1; jalr_target = 32'h0000_0103; imm_val = 32'h40;
        end
        if (front == 32'h108 && !d_wrap) begin
          pc_next_sel = 1'b1; jalr_target = 32'hFFFF_FFF9;
        end
      end else if (bp_left > 0) begin
        imem_req_ready = 1'b0;
        bp_left--;
      end else if (i >= 1190 && i < 1200) begin
        lat = 3;
      end else begin
        lat   = 1 + int'($urandom % 3);
        imem_req_ready = ($urandom % 4) != 0;
        stall = ($urandom % 4) == 0;
        sel   = int'($urandom % 10);
        pc_add_sel  = (sel == 0) || (sel == 2);
        pc_next_sel = (sel == 1) || (sel == 2);
        imm_val     = $urandom;
        jalr_target = $urandom;
      end
    end
    @(negedge clk);
    chk("directed_done", {31'd0, dir_done}, 1);
    chk("progress", {31'd0, (n_cons >= 150)}, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
